summer_decoder: RTL



---
 rtl/summer_pkg.sv | 21 ++
 rtl/summer_decoder_if.sv | 27 ++
 rtl/summer_dec_fifo.sv | 158 +++++++++++++++
 rtl/summer_decoder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/summer_pkg.sv
// Shared definitions for the summer / summer_decoder pair: default data
// width, FIFO occupancy-state encoding and the modular-subtraction helper.
package summer_pkg;

  // Default sum/data width; must agree with the upstream summer.
  localparam int SUMMER_DATA_W = 4;

  // Occupancy state of the decoder output FIFO.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  // Unsigned subtraction a - b; the caller truncates to its data width,
  // which makes the result modulo 2^width without overflow detection.
  function automatic logic [31:0] sub_mod(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/summer_decoder_if.sv
// Stream interface of summer_decoder: the incoming sum stream (no
// backpressure, with a restart strobe) and the outgoing valid/ready stream.
// master = stream producer/consumer side, slave = the decoder.
interface summer_decoder_if
  import summer_pkg::*;
#(
  parameter int DATA_W = SUMMER_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_clr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_clr, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_clr, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/summer_dec_fifo.sv
// Output FIFO of summer_decoder: storage, wrapping pointers, occupancy level
// and an EMPTY/PARTIAL/FULL state machine. The head word is registered so
// rdata_o/valid_o come straight from flops; rdata_o is 0 while empty.
// clr_i flushes the FIFO and suppresses any coincident push or pop.
module summer_dec_fifo
  import summer_pkg::*;
#(
  parameter int DATA_W = SUMMER_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_req_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  fifo_state_t       state_q, state_d;
  logic              empty_s, full_s;
  logic              pop_s, push_ok_s;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              valid_q, valid_d;

  // A pop needs a non-empty FIFO; a push into a full FIFO needs a same-cycle pop.
  assign pop_s     = pop_req_i & ~empty_s & ~clr_i;
  assign push_ok_s = push_i & ~clr_i & (~full_s | pop_s);

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next-state: clear wins, else step on push-only / pop-only.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_ok_s) state_d = PARTIAL;
          else           state_d = EMPTY;
        end
        PARTIAL: begin
          if (push_ok_s && !pop_s && (level_q == LVL_W'(DEPTH - 1)))
            state_d = FULL;
          else if (pop_s && !push_ok_s && (level_q == LVL_W'(1)))
            state_d = EMPTY;
          else
            state_d = PARTIAL;
        end
        FULL: begin
          if (pop_s && !push_ok_s) state_d = PARTIAL;
          else                     state_d = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Full/empty flags decoded from the occupancy state.
  always_comb begin
    empty_s = 1'b0;
    full_s  = 1'b0;
    case (state_q)
      EMPTY:   empty_s = 1'b1;
      PARTIAL: empty_s = 1'b0;
      FULL:    full_s  = 1'b1;
      default: empty_s = 1'b1;
    endcase
  end

  // Pointer, level and registered-head next values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = {DATA_W{1'b0}};
    valid_d  = 1'b0;
    if (clr_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      level_d  = {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (pop_s)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
    // The new head is the word being written only when it lands on the
    // slot the read pointer will point at (push into an empty FIFO).
    if (level_d == {LVL_W{1'b0}}) begin
      head_d  = {DATA_W{1'b0}};
      valid_d = 1'b0;
    end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d  = wdata_i;
      valid_d = 1'b1;
    end else begin
      head_d  = mem_q[rd_ptr_d];
      valid_d = 1'b1;
    end
  end

  // Pointer, level and head registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      head_q   <= {DATA_W{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {DATA_W{1'b0}};
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign rdata_o = head_q;
  assign valid_o = valid_q;
  assign full_o  = full_s;
  assign level_o = level_q;

endmodule

// File: rtl/summer_decoder.sv
// summer_decoder: inverts the pairwise-sum stream of summer
// (x_k = s_k - x_(k-1), x_(-1) = 0) and buffers the recovered words in a
// FIFO behind a valid/ready port. Words arriving while the FIFO is full
// (and not being popped) are dropped and set the sticky overflow flag.
// Optional feature macro SUMMER_DEC_DROP_CNT_EN adds a 16-bit saturating
// drop counter output drop_cnt.
module summer_decoder
  import summer_pkg::*;
#(
  parameter int DATA_W = SUMMER_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  summer_decoder_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
`ifdef SUMMER_DEC_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] dec_s;
  logic              full_s;
  logic              drop_s, push_s;
  logic              overflow_q, overflow_d;

  // Decoded word: current sum minus the previously recovered value.
  assign dec_s = DATA_W'(sub_mod(32'(bus.in_data), 32'(prev_q)));

  // Push/drop decision: a full FIFO only accepts when the head is popped.
  always_comb begin
    drop_s = 1'b0;
    push_s = 1'b0;
    if (bus.in_clr) begin
      drop_s = 1'b0;
      push_s = 1'b0;
    end else if (bus.in_valid) begin
      if (full_s && !bus.out_ready) drop_s = 1'b1;
      else                          push_s = 1'b1;
    end else begin
      drop_s = 1'b0;
      push_s = 1'b0;
    end
  end

  // History and sticky-overflow next values; history advances on dropped words too.
  always_comb begin
    prev_d     = prev_q;
    overflow_d = overflow_q;
    if (bus.in_clr) begin
      prev_d     = {DATA_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (bus.in_valid) prev_d = dec_s;
      else              prev_d = prev_q;
      if (drop_s) overflow_d = 1'b1;
      else        overflow_d = overflow_q;
    end
  end

  // History and overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= {DATA_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifdef SUMMER_DEC_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Drop counter next value: cleared by in_clr, saturates at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.in_clr) begin
      drop_cnt_d = 16'd0;
    end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  summer_dec_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.in_clr),
    .push_i    (push_s),
    .pop_req_i (bus.out_ready),
    .wdata_i   (dec_s),
    .rdata_o   (bus.out_data),
    .valid_o   (bus.out_valid),
    .full_o    (full_s),
    .level_o   (level)
  );

endmodule
